dmem_io_arbiter: RTL and testbench

- Sequences every data-side access in the CPU and shares the single-port synchronous data memory between two requesters: the CPU load/store path and the UART program loader.
- Decodes the memory-mapped IO window in-house and owns the LED output register and switch input sampling.
- Sits between the CPU datapath/loader and the data-memory BRAM, LED pins and switch pins.

---
 rtl/dmem_io_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_dmem_io_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_io_arbiter.sv
// Data-side access sequencer: shares the single-port data BRAM between CPU and UART loader,
// decodes the IO window (LED register, switch input). Optional macro ROUND_ROBIN_EN.
module dmem_io_arbiter #(
  parameter int          MEM_AW  = 14,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
  parameter logic [9:0]  LED_OFS = 10'h060,
  parameter logic [9:0]  SW_OFS  = 10'h070
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic [31:0]       ldr_addr,
  input  logic [31:0]       ldr_wdata,
  output logic              ldr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic              grant_ldr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_ACC = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } state_e;

  function automatic logic is_io(input logic [21:0] hi);
    return hi == IO_BASE[31:10];
  endfunction

  function automatic logic ofs_hit(input logic [7:0] a, input logic [7:0] ofs);
    return a == ofs;
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  state_e             state_q, state_d;
  logic               acc_we_q, acc_we_d;
  logic               grant_ldr_q, grant_ldr_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]        cpu_rdata_q, cpu_rdata_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic               ldr_ack_q, ldr_ack_d;
  logic [15:0]        led_q, led_d;
  logic               pick_ldr_s, pick_cpu_s, ldr_io_s, cpu_io_s;
  logic               unused_s;

  assign unused_s = ^{cpu_addr[1:0], ldr_addr[1:0]};
  assign ldr_io_s = is_io(ldr_addr[31:10]);
  assign cpu_io_s = is_io(cpu_addr[31:10]);

`ifdef ROUND_ROBIN_EN
  // last_grant_q = 1 means the loader won the most recent arbitration
  logic last_grant_q, last_grant_d;
  assign pick_ldr_s = ldr_req && (!cpu_req || !last_grant_q);
`else
  assign pick_ldr_s = ldr_req;
`endif
  assign pick_cpu_s = cpu_req && !pick_ldr_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_ldr_s) begin
          state_d = ldr_io_s ? DONE : MEM_ACC;
        end else if (pick_cpu_s) begin
          state_d = cpu_io_s ? DONE : MEM_ACC;
        end else begin
          state_d = IDLE;
        end
      end
      MEM_ACC: state_d = acc_we_q ? DONE : RD_WAIT;
      RD_WAIT: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; all outputs are registered from these
  always_comb begin
    grant_ldr_d = grant_ldr_q;
    acc_we_d    = acc_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    led_d       = led_q;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
`ifdef ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_ldr_s) begin
          grant_ldr_d = 1'b1;
          acc_we_d    = 1'b1;
`ifdef ROUND_ROBIN_EN
          last_grant_d = 1'b1;
`endif
          if (!ldr_io_s) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = ldr_addr[MEM_AW+1:2];
            mem_wdata_d = ldr_wdata;
          end else begin
            mem_en_d = 1'b0;
          end
        end else if (pick_cpu_s) begin
          grant_ldr_d = 1'b0;
          acc_we_d    = cpu_we;
`ifdef ROUND_ROBIN_EN
          last_grant_d = 1'b0;
`endif
          if (!cpu_io_s) begin
            mem_en_d    = 1'b1;
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr[MEM_AW+1:2];
            mem_wdata_d = cpu_wdata;
          end else if (cpu_we) begin
            led_d = ofs_hit(cpu_addr[9:2], LED_OFS[9:2]) ? cpu_wdata[15:0] : led_q;
          end else begin
            cpu_rdata_d = ofs_hit(cpu_addr[9:2], SW_OFS[9:2]) ? sext16(sw_in) : 32'h0000_0000;
          end
        end else begin
          grant_ldr_d = 1'b0;
        end
      end
      MEM_ACC: acc_we_d    = acc_we_q;
      RD_WAIT: cpu_rdata_d = mem_rdata;
      DONE:    acc_we_d    = acc_we_q;
      default: acc_we_d    = acc_we_q;
    endcase
    if (state_d == DONE) begin
      cpu_ack_d = !grant_ldr_d;
      ldr_ack_d = grant_ldr_d;
    end else begin
      cpu_ack_d = 1'b0;
      ldr_ack_d = 1'b0;
    end
    if (state_d == IDLE) begin
      grant_ldr_d = 1'b0;
    end else begin
      grant_ldr_d = grant_ldr_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_we_q    <= 1'b0;
      grant_ldr_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
      cpu_rdata_q <= 32'h0000_0000;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      led_q       <= 16'h0000;
    end else begin
      acc_we_q    <= acc_we_d;
      grant_ldr_q <= grant_ldr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      led_q       <= led_d;
    end
  end

`ifdef ROUND_ROBIN_EN
  // Arbitration history register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign led_out   = led_q;
  assign grant_ldr = grant_ldr_q;

endmodule

// File: tb/tb_dmem_io_arbiter.sv
// Directed bench for dmem_io_arbiter with a behavioural BRAM and an ack-ordered scoreboard.
module tb_dmem_io_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic        ldr_req;
  logic [31:0] ldr_addr, ldr_wdata;
  logic        ldr_ack;
  logic        mem_en, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] sw_in, led_out;
  logic        grant_ldr;

  int checks = 0;
  int passed = 0;

  typedef struct {
    bit          is_ldr;
    bit          chk_rd;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] bram [0:16383];

  dmem_io_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .sw_in(sw_in), .led_out(led_out), .grant_ldr(grant_ldr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: every ack pops the next expected completion
  always @(negedge clk) begin
    if (rst_n && (cpu_ack || ldr_ack)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ack_who", 32'(ldr_ack), 32'(e.is_ldr));
        check("ack_single", 32'(cpu_ack & ldr_ack), 32'd0);
        check("ack_mem_en", 32'(mem_en), 32'd0);
        check("ack_grant_ldr", 32'(grant_ldr), 32'(e.is_ldr));
        if (e.chk_rd) check("rdata", cpu_rdata, e.rdata);
      end
    end
  end

  task automatic push_exp(input bit is_ldr, input bit chk_rd, input logic [31:0] rd);
    exp_t e;
    e.is_ldr = is_ldr;
    e.chk_rd = chk_rd;
    e.rdata  = rd;
    sb_q.push_back(e);
  endtask

  task automatic run_one(input string tag, input bit is_ldr, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input int exp_lat, input bit exp_mem);
    int lat;
    bit got, seen_mem;
    push_exp(is_ldr, !we, exp_rd);
    if (is_ldr) begin
      ldr_req = 1'b1; ldr_addr = addr; ldr_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    lat = 0; got = 1'b0; seen_mem = 1'b0;
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (mem_en) seen_mem = 1'b1;
      if (lat == 1 && exp_mem) begin
        check({tag, "_mem_we"}, 32'(mem_we), 32'(we));
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(addr[15:2]));
        if (we) check({tag, "_mem_wdata"}, mem_wdata, wdata);
      end
      got = is_ldr ? ldr_ack : cpu_ack;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_mem_seen"}, 32'(seen_mem), 32'(exp_mem));
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, c_lat, l_lat;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    ldr_req = 1'b0; ldr_addr = 32'd0; ldr_wdata = 32'd0;
    sw_in = 16'h0000; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_ldr_ack", 32'(ldr_ack), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_grant", 32'(grant_ldr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_one("cpu_st_mem", 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 2, 1'b1);
    run_one("cpu_ld_mem", 1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 3, 1'b1);
    run_one("cpu_st_led", 1'b0, 1'b1, 32'hFFFF_FC60, 32'h0000_A5A5, 32'd0, 1, 1'b0);
    check("led_after_store", 32'(led_out), 32'h0000_A5A5);
    sw_in = 16'h8001;
    run_one("cpu_ld_sw", 1'b0, 1'b0, 32'hFFFF_FC70, 32'd0, 32'hFFFF_8001, 1, 1'b0);
    sw_in = 16'h7FFE;
    run_one("cpu_ld_sw_pos", 1'b0, 1'b0, 32'hFFFF_FC70, 32'd0, 32'h0000_7FFE, 1, 1'b0);
    run_one("cpu_ld_io_other", 1'b0, 1'b0, 32'hFFFF_FC80, 32'd0, 32'd0, 1, 1'b0);
    run_one("cpu_st_io_other", 1'b0, 1'b1, 32'hFFFF_FC84, 32'h0000_1234, 32'd0, 1, 1'b0);
    check("led_after_other", 32'(led_out), 32'h0000_A5A5);
    run_one("ldr_st_io", 1'b1, 1'b1, 32'hFFFF_FC60, 32'h0000_5A5A, 32'd0, 1, 1'b0);
    check("led_after_ldr", 32'(led_out), 32'h0000_A5A5);
    run_one("ldr_st_mem", 1'b1, 1'b1, 32'h0000_0040, 32'h1111_2222, 32'd0, 2, 1'b1);

    // Both requesters rise together; last grant went to the loader
`ifdef ROUND_ROBIN_EN
    push_exp(1'b0, 1'b0, 32'd0);
    push_exp(1'b1, 1'b0, 32'd0);
`else
    push_exp(1'b1, 1'b0, 32'd0);
    push_exp(1'b0, 1'b0, 32'd0);
`endif
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'hCAFE_0001;
    ldr_req = 1'b1; ldr_addr = 32'h0000_0040; ldr_wdata = 32'h55AA_55AA;
    lat = 0; c_lat = 0; l_lat = 0;
    while ((c_lat == 0 || l_lat == 0) && lat < 20) begin
      @(negedge clk);
      lat++;
      if (cpu_ack && c_lat == 0) begin c_lat = lat; cpu_req = 1'b0; end
      if (ldr_ack && l_lat == 0) begin l_lat = lat; ldr_req = 1'b0; end
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
`ifdef ROUND_ROBIN_EN
    check("both_cpu_lat", 32'(c_lat), 32'd2);
    check("both_ldr_lat", 32'(l_lat), 32'd5);
`else
    check("both_ldr_lat", 32'(l_lat), 32'd2);
    check("both_cpu_lat", 32'(c_lat), 32'd5);
`endif
    @(negedge clk);
    run_one("cpu_ld_20", 1'b0, 1'b0, 32'h0000_0020, 32'd0, 32'hCAFE_0001, 3, 1'b1);
    run_one("cpu_ld_40", 1'b0, 1'b0, 32'h0000_0040, 32'd0, 32'h55AA_55AA, 3, 1'b1);

    // Reset in RD_WAIT abandons the load; it restarts once reset releases
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rdw_rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rdw_rst_mem_en", 32'(mem_en), 32'd0);
    check("rdw_rst_rdata", cpu_rdata, 32'd0);
    check("rdw_rst_led", 32'(led_out), 32'd0);
    check("rdw_rst_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    check("rdw_rst_hold_ack", 32'(cpu_ack), 32'd0);
    push_exp(1'b0, 1'b1, 32'hDEAD_BEEF);
    rst_n = 1'b1;
    lat = 0;
    while (!cpu_ack && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("restart_latency", 32'(lat), 32'd3);
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
